// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: round-robin grant,
// one transaction in flight, RAM read latency absorbed. Define FIXED_PRIO_EN for port-0 priority.
module ram_port_arbiter #(
    parameter int RAM_SIZE = 16,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [RAM_SIZE-1:0] addr0,
    input  logic [RAM_SIZE-1:0] addr1,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W-1:0]   wdata1,
    output logic                ack0,
    output logic                ack1,
    output logic [DATA_W-1:0]   rdata0,
    output logic [DATA_W-1:0]   rdata1,
    output logic [RAM_SIZE-1:0] ram_address,
    output logic                ram_we,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    // Handshake: a requester raises reqN with stable we/addr/wdata and keeps it high until
    // ackN pulses for one cycle; req is only sampled in IDLE, so a req still high then is new.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_e;

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e              state_q,      state_d;
    logic                winner_q,     winner_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q,         we_d;
    logic [RAM_SIZE-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0]   wdata_q,      wdata_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [DATA_W-1:0]   rdata0_q,     rdata0_d;
    logic [DATA_W-1:0]   rdata1_q,     rdata1_d;

    logic grant1;

    always_comb begin
`ifdef FIXED_PRIO_EN
        grant1 = !req0;
`else
        // Port 1 wins when alone, or when both ask and port 0 had the previous grant.
        grant1 = req1 && (!req0 || !last_grant_q);
`endif
    end

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    winner_d     = grant1;
                    last_grant_d = grant1;
                    we_d         = grant1 ? we1    : we0;
                    addr_d       = grant1 ? addr1  : addr0;
                    wdata_d      = grant1 ? wdata1 : wdata0;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (winner_q) begin
                        rdata1_d = ram_rdata;
                    end else begin
                        rdata0_d = ram_rdata;
                    end
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            winner_q     <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Address and data stay on the latched values through WAIT so the RAM read pipeline sees them.
    assign ram_address = addr_q;
    assign ram_wdata   = wdata_q;
    assign ram_we      = (state_q == S_ACCESS) && we_q;
    assign ack0        = (state_q == S_ACK) && !winner_q;
    assign ack1        = (state_q == S_ACK) && winner_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model (memory array, arbitration rule, latency formula).
module tb_ram_port_arbiter;

    localparam int RD_LAT_A = 1;
    localparam int RD_LAT_B = 3;

    logic clk;
    logic rst;

    logic        a_req0, a_req1, a_we0, a_we1;
    logic [15:0] a_addr0, a_addr1, a_wdata0, a_wdata1;
    logic        a_ack0, a_ack1, a_ram_we, a_busy;
    logic [15:0] a_rdata0, a_rdata1, a_ram_address, a_ram_wdata, a_ram_rdata;
    logic [1:0]  a_dbg_state;

    logic        b_req0, b_req1, b_we0, b_we1;
    logic [15:0] b_addr0, b_addr1, b_wdata0, b_wdata1;
    logic        b_ack0, b_ack1, b_ram_we, b_busy;
    logic [15:0] b_rdata0, b_rdata1, b_ram_address, b_ram_wdata, b_ram_rdata;
    logic [1:0]  b_dbg_state;

    int total;
    int bad;

    // Reference model state
    bit          lg;
    logic [15:0] ref_mem [256];
    logic [15:0] exp_rd  [2];
    int          obs_grants[$];

    ram_port_arbiter #(.RAM_SIZE(16), .DATA_W(16), .RD_LAT(RD_LAT_A)) dut_a (
        .clk(clk), .rst(rst),
        .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
        .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
        .ack0(a_ack0), .ack1(a_ack1), .rdata0(a_rdata0), .rdata1(a_rdata1),
        .ram_address(a_ram_address), .ram_we(a_ram_we), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata), .busy(a_busy), .dbg_state(a_dbg_state)
    );

    ram_port_arbiter #(.RAM_SIZE(16), .DATA_W(16), .RD_LAT(RD_LAT_B)) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
        .ram_address(b_ram_address), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy), .dbg_state(b_dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM environment models ----------------
    function automatic logic [15:0] ram_init(input logic [7:0] a);
        return (a == 8'hFF) ? 16'h1234 : {a, ~a};
    endfunction

    logic [15:0] mem_a [256];
    bit          wr_a  [256];
    logic [15:0] pipe_a;
    always @(posedge clk) begin
        if (a_ram_we) begin
            mem_a[a_ram_address[7:0]] <= a_ram_wdata;
            wr_a[a_ram_address[7:0]]  <= 1'b1;
        end
        pipe_a <= wr_a[a_ram_address[7:0]] ? mem_a[a_ram_address[7:0]] : ram_init(a_ram_address[7:0]);
    end
    assign a_ram_rdata = pipe_a;

    logic [15:0] mem_b [256];
    bit          wr_b  [256];
    logic [15:0] pipe_b [RD_LAT_B];
    always @(posedge clk) begin
        if (b_ram_we) begin
            mem_b[b_ram_address[7:0]] <= b_ram_wdata;
            wr_b[b_ram_address[7:0]]  <= 1'b1;
        end
        pipe_b[0] <= wr_b[b_ram_address[7:0]] ? mem_b[b_ram_address[7:0]] : ram_init(b_ram_address[7:0]);
        for (int i = 1; i < RD_LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign b_ram_rdata = pipe_b[RD_LAT_B-1];

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic r0, input logic r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
`ifdef FIXED_PRIO_EN
        return 0;
`else
        return lg ? 0 : 1;
`endif
    endfunction

    task automatic model_reset();
        lg        = 1'b1;
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;
    endtask

    // Called in an IDLE cycle with at least one request raised; returns in the IDLE cycle after ack.
    task automatic run_txn(input bit hold);
        int          w;
        int          lat;
        bit          twe;
        bit          scr;
        logic [15:0] taddr;
        logic [15:0] twd;
        w     = pick(a_req0, a_req1);
        twe   = (w == 1) ? a_we1 : a_we0;
        taddr = (w == 1) ? a_addr1 : a_addr0;
        twd   = (w == 1) ? a_wdata1 : a_wdata0;
        lat   = twe ? 2 : 2 + RD_LAT_A;
        lg    = (w == 1);
        if (twe) ref_mem[taddr[7:0]] = twd;
        scr = !hold && ($urandom_range(0, 3) == 0);
        for (int k = 1; k <= lat; k++) begin
            step();
            if (k == 1 && scr) begin
                if (w == 0) begin
                    a_addr0 = 16'($urandom); a_wdata0 = 16'($urandom);
                    a_we0 = ~a_we0; a_req0 = 1'($urandom_range(0, 1));
                end else begin
                    a_addr1 = 16'($urandom); a_wdata1 = 16'($urandom);
                    a_we1 = ~a_we1; a_req1 = 1'($urandom_range(0, 1));
                end
            end
            chk("busy", 32'(a_busy), 32'(1));
            chk("ram_we", 32'(a_ram_we), 32'(k == 1 && twe));
            if (k == 1) begin
                chk("ram_address", 32'(a_ram_address), 32'(taddr));
                if (twe) chk("ram_wdata", 32'(a_ram_wdata), 32'(twd));
            end
            chk("ack0", 32'(a_ack0), 32'(k == lat && w == 0));
            chk("ack1", 32'(a_ack1), 32'(k == lat && w == 1));
            if (k == lat) begin
                obs_grants.push_back(a_ack1 ? 1 : (a_ack0 ? 0 : -1));
                if (!twe) exp_rd[w] = ref_mem[taddr[7:0]];
                chk("rdata0", 32'(a_rdata0), 32'(exp_rd[0]));
                chk("rdata1", 32'(a_rdata1), 32'(exp_rd[1]));
            end
        end
        step();
        chk("idle_busy", 32'(a_busy), 32'(0));
        chk("idle_ack0", 32'(a_ack0), 32'(0));
        chk("idle_ack1", 32'(a_ack1), 32'(0));
        if (!hold) begin
            if (w == 0) a_req0 = 1'b0;
            else        a_req1 = 1'b0;
        end
    endtask

    task automatic check_grants(input string tag, input int e0, input int e1, input int e2, input int e3);
        int exp_g[4];
        exp_g = '{e0, e1, e2, e3};
        chk({tag, "_count"}, 32'(obs_grants.size()), 32'(4));
        for (int i = 0; i < 4 && i < obs_grants.size(); i++) begin
            chk($sformatf("%s_%0d", tag, i), 32'(obs_grants[i]), 32'(exp_g[i]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = ram_init(8'(i));
        model_reset();
        rst = 1'b1;
        a_req0 = 0; a_req1 = 0; a_we0 = 0; a_we1 = 0;
        a_addr0 = 0; a_addr1 = 0; a_wdata0 = 0; a_wdata1 = 0;
        b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
        b_addr0 = 0; b_addr1 = 0; b_wdata0 = 0; b_wdata1 = 0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_ack0", 32'(a_ack0), 32'(0));
        chk("rst_ack1", 32'(a_ack1), 32'(0));
        chk("rst_busy", 32'(a_busy), 32'(0));
        chk("rst_ram_we", 32'(a_ram_we), 32'(0));
        chk("rst_ram_address", 32'(a_ram_address), 32'(0));
        chk("rst_ram_wdata", 32'(a_ram_wdata), 32'(0));
        chk("rst_rdata0", 32'(a_rdata0), 32'(0));
        chk("rst_rdata1", 32'(a_rdata1), 32'(0));

        // Port 0 write then read-back of the same word
        a_req0 = 1; a_we0 = 1; a_addr0 = 16'h0010; a_wdata0 = 16'hBEEF;
        run_txn(1'b0);
        a_req0 = 1; a_we0 = 0; a_addr0 = 16'h0010;
        run_txn(1'b0);
        chk("t3_rdata0", 32'(a_rdata0), 32'h0000BEEF);
        chk("t3_rdata1", 32'(a_rdata1), 32'(0));

        // Reset in the ACCESS cycle of a write aborts it
        a_req0 = 1; a_we0 = 1; a_addr0 = 16'h0004; a_wdata0 = 16'hDEAD;
        step();
        chk("t1_access_we", 32'(a_ram_we), 32'(1));
        rst = 1'b1;
        #1;
        chk("t1_we_drop", 32'(a_ram_we), 32'(0));
        chk("t1_busy", 32'(a_busy), 32'(0));
        chk("t1_ack0", 32'(a_ack0), 32'(0));
        chk("t1_rdata0", 32'(a_rdata0), 32'(0));
        a_req0 = 0;
        model_reset();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_post_ack0", 32'(a_ack0), 32'(0));
            chk("t1_post_busy", 32'(a_busy), 32'(0));
        end

        // Both ports held high from reset
        obs_grants.delete();
        a_req0 = 1; a_we0 = 0; a_addr0 = 16'h0001;
        a_req1 = 1; a_we1 = 0; a_addr1 = 16'h0002;
        for (int i = 0; i < 4; i++) run_txn(1'b1);
`ifdef FIXED_PRIO_EN
        check_grants("t4_grant", 0, 0, 0, 0);
`else
        check_grants("t4_grant", 0, 1, 0, 1);
`endif

        // Three held transactions, then port 0 drops out
        obs_grants.delete();
        for (int i = 0; i < 3; i++) run_txn(1'b1);
        a_req0 = 0;
        run_txn(1'b0);
        a_req1 = 0;
`ifdef FIXED_PRIO_EN
        check_grants("t5_grant", 0, 0, 0, 1);
`else
        check_grants("t5_grant", 0, 1, 0, 1);
`endif

        // RD_LAT=3 instance: port 1 read of 0x00FF
        b_req1 = 1; b_we1 = 0; b_addr1 = 16'h00FF;
        chk("t6_busy0", 32'(b_busy), 32'(0));
        for (int k = 1; k <= 2 + RD_LAT_B; k++) begin
            step();
            chk("t6_busy", 32'(b_busy), 32'(1));
            chk("t6_ack1", 32'(b_ack1), 32'(k == 2 + RD_LAT_B));
            chk("t6_ack0", 32'(b_ack0), 32'(0));
        end
        chk("t6_rdata1", 32'(b_rdata1), 32'h00001234);
        chk("t6_rdata0", 32'(b_rdata0), 32'(0));
        step();
        b_req1 = 0;
        chk("t6_busy_end", 32'(b_busy), 32'(0));

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            if (!a_req0 && $urandom_range(0, 1) == 1) begin
                a_req0 = 1; a_we0 = 1'($urandom_range(0, 1));
                a_addr0 = 16'($urandom_range(0, 15)); a_wdata0 = 16'($urandom);
            end
            if (!a_req1 && $urandom_range(0, 1) == 1) begin
                a_req1 = 1; a_we1 = 1'($urandom_range(0, 1));
                a_addr1 = 16'($urandom_range(0, 15)); a_wdata1 = 16'($urandom);
            end
            if (a_req0 || a_req1) begin
                run_txn(1'b0);
            end else begin
                step();
                chk("rnd_idle_busy", 32'(a_busy), 32'(0));
                chk("rnd_idle_ack", 32'({a_ack0, a_ack1}), 32'(0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
